// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: write-back, read and issue signals between the pipeline
// and the register file / scoreboard. The master side is the pipeline
// (write-back and decode). The slave side is the register file.
interface reg_file_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            reg_write_wb;
    logic [AW-1:0]   rd_wb;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rd_en;
    logic            issue_valid;
    logic            issue_writes;
    logic [AW-1:0]   issue_rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            stall;
    logic            sb_err;

    modport master (
        output reg_write_wb, rd_wb, wb_data, rs1_addr, rs2_addr, rd_en,
               issue_valid, issue_writes, issue_rd,
        input  rs1_data, rs2_data, stall, sb_err
    );

    modport slave (
        input  reg_write_wb, rd_wb, wb_data, rs1_addr, rs2_addr, rd_en,
               issue_valid, issue_writes, issue_rd,
        output rs1_data, rs2_data, stall, sb_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: architectural register file with a per-register scoreboard.
// - r0 reads as zero and ignores writes.
// - Reads are registered (latency 1) and hold their value when rd_en is low.
// - Each register has a pending-write counter. A read hazard or a full
//   counter raises a combinational stall toward decode.
// - A write-back to a register with no pending write sets sticky sb_err.
// Optional feature macro REGFILE_BYPASS_EN:
// - A same-cycle write-back is forwarded to the read ports.
// - That write-back also clears its own hazard.
// Without the macro, reads see the pre-write value and stall uses the raw counters.
module reg_file_sb #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_sb_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREGS-1:0][XLEN-1:0]  regs_q, regs_d;
    logic [NREGS-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [XLEN-1:0]             rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]             rs2_data_q, rs2_data_d;
    logic                        sb_err_q, sb_err_d;

    logic [NREGS-1:0] wb_hit;     // write-back lands on register r this cycle
    logic [NREGS-1:0] iss_hit;    // accepted issue targets register r
    logic [NREGS-1:0] eff_nz;     // register r still has an outstanding write
    logic             issue_req;
    logic             issue_acc;
    logic             ovf_stall;
    logic             raw_stall;
    logic             stall;
    logic [XLEN-1:0]  rd1_val, rd2_val;

    assign issue_req = bus.issue_valid && bus.issue_writes && (bus.issue_rd != '0);
    assign issue_acc = issue_req && !stall;

    // Per-register hit decode and effective pending status
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        localparam logic [AW-1:0] IDX = AW'(r);
        if (r == 0) begin : g_r0
            assign wb_hit[r]  = 1'b0;
            assign iss_hit[r] = 1'b0;
        end else begin : g_rn
            assign wb_hit[r]  = bus.reg_write_wb && (bus.rd_wb == IDX);
            assign iss_hit[r] = issue_acc && (bus.issue_rd == IDX);
        end
`ifdef REGFILE_BYPASS_EN
        // pend - wb_hit is nonzero exactly when pend differs from wb_hit
        assign eff_nz[r] = (pend_q[r] != {{(CNT_W-1){1'b0}}, wb_hit[r]});
`else
        assign eff_nz[r] = (pend_q[r] != '0);
`endif
    end

    assign raw_stall = bus.rd_en && (eff_nz[bus.rs1_addr] || eff_nz[bus.rs2_addr]);
    assign ovf_stall = issue_req && (pend_q[bus.issue_rd] == CNT_MAX);
    assign stall     = raw_stall || ovf_stall;

    // Read-port source select, including optional write-through forwarding
    always_comb begin
        rd1_val = regs_q[bus.rs1_addr];
        rd2_val = regs_q[bus.rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_hit[bus.rs1_addr]) rd1_val = bus.wb_data;
        if (wb_hit[bus.rs2_addr]) rd2_val = bus.wb_data;
`endif
        if (bus.rs1_addr == '0) rd1_val = '0;
        if (bus.rs2_addr == '0) rd2_val = '0;
    end

    // Next-state for array, counters, read registers and error flag
    always_comb begin
        regs_d     = regs_q;
        pend_d     = pend_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        sb_err_d   = sb_err_q;
        if (bus.rd_en) begin
            rs1_data_d = rd1_val;
            rs2_data_d = rd2_val;
        end
        for (int r = 1; r < NREGS; r++) begin
            if (wb_hit[r]) begin
                regs_d[r] = bus.wb_data;
                if (pend_q[r] == '0) sb_err_d = 1'b1;
            end
            // Same-cycle issue and write-back cancel out
            if (iss_hit[r] && !wb_hit[r])
                pend_d[r] = pend_q[r] + CNT_ONE;
            else if (wb_hit[r] && !iss_hit[r] && pend_q[r] != '0)
                pend_d[r] = pend_q[r] - CNT_ONE;
        end
    end

    // State registers; reset drops any write-back or issue in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q     <= '0;
            pend_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign bus.rs1_data = rs1_data_q;
    assign bus.rs2_data = rs2_data_q;
    assign bus.stall    = stall;
    assign bus.sb_err   = sb_err_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb.
// The stimulus task drives one cycle of inputs. It pushes that cycle's expected
// outputs, taken from an array/counter model, and then advances the model.
// A monitor pops the expectations mid-cycle and compares them with the DUT outputs.
module tb_reg_file_sb;
    logic clk;
    logic reset;

    reg_file_sb_if #(.XLEN(32), .AW(5)) bus ();

    reg_file_sb #(.NREGS(32), .XLEN(32), .AW(5), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        err;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    // behavioural model
    logic [31:0] m_regs[32];
    int          m_pend[32];
    logic [31:0] m_rs1, m_rs2;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Mid-cycle monitor: one expectation per driven cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".stall"}, {31'd0, bus.stall}, {31'd0, e.stall});
            chk({e.tag, ".rs1"}, bus.rs1_data, e.rs1);
            chk({e.tag, ".rs2"}, bus.rs2_data, e.rs2);
            chk({e.tag, ".err"}, {31'd0, bus.sb_err}, {31'd0, e.err});
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic hw,
                                           input logic [4:0] rd, input logic [31:0] d);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (hw && rd == a) return d;
`endif
        return m_regs[a];
    endfunction

    task automatic step(input logic rst, input logic we, input logic [4:0] rd,
                        input logic [31:0] d, input logic rden,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic iv, input logic iw, input logic [4:0] ird,
                        input string tag);
        logic  hw, st, acc;
        int    e1, e2;
        exp_t  e;
        logic [31:0] n1, n2;
        @(posedge clk);
        #1;
        reset            = rst;
        bus.reg_write_wb = we;
        bus.rd_wb        = rd;
        bus.wb_data      = d;
        bus.rd_en        = rden;
        bus.rs1_addr     = a1;
        bus.rs2_addr     = a2;
        bus.issue_valid  = iv;
        bus.issue_writes = iw;
        bus.issue_rd     = ird;

        hw = we && (rd != 5'd0);
        e1 = m_pend[a1];
        e2 = m_pend[a2];
`ifdef REGFILE_BYPASS_EN
        if (hw && rd == a1) e1 = e1 - 1;
        if (hw && rd == a2) e2 = e2 - 1;
`endif
        st = (rden && (e1 != 0 || e2 != 0)) ||
             (iv && iw && ird != 5'd0 && m_pend[ird] == 3);
        e.stall = st; e.rs1 = m_rs1; e.rs2 = m_rs2; e.err = m_err; e.tag = tag;
        exp_q.push_back(e);

        if (rst) begin
            foreach (m_regs[i]) begin m_regs[i] = 32'd0; m_pend[i] = 0; end
            m_rs1 = 32'd0; m_rs2 = 32'd0; m_err = 1'b0;
        end else begin
            n1 = m_read(a1, hw, rd, d);
            n2 = m_read(a2, hw, rd, d);
            if (rden) begin m_rs1 = n1; m_rs2 = n2; end
            acc = iv && iw && ird != 5'd0 && !st;
            if (hw) begin
                if (m_pend[rd] == 0) m_err = 1'b1;
                m_regs[rd] = d;
            end
            if (!(acc && hw && ird == rd)) begin
                if (acc) m_pend[ird]++;
                if (hw && m_pend[rd] > 0) m_pend[rd]--;
            end
        end
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_rst(input string tag);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        logic [4:0]  rd, a1, a2, ird;
        logic [31:0] d;
        int          cand[$];
        reset = 1'b1;
        bus.reg_write_wb = 0; bus.rd_wb = 0; bus.wb_data = 0; bus.rd_en = 0;
        bus.rs1_addr = 0; bus.rs2_addr = 0; bus.issue_valid = 0;
        bus.issue_writes = 0; bus.issue_rd = 0;
        foreach (m_regs[i]) begin m_regs[i] = 32'd0; m_pend[i] = 0; end
        m_rs1 = 0; m_rs2 = 0; m_err = 0;

        // 1: reset state and a read after reset
        do_rst("t1.rst0");
        do_rst("t1.rst1");
        step(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, "t1.rd");
        idle("t1.chk");

        // 2: write then read, write to r0 discarded
        step(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, "t2.wb");
        step(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, "t2.rd");
        idle("t2.chk");
        step(0, 1, 0, 32'd1, 0, 0, 0, 0, 0, 0, "t2.wb0");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "t2.rd0");
        idle("t2.chk0");
        do_rst("t2.rst");

        // 3: RAW hazard, write-back with concurrent read
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, "t3.iss");
        step(0, 0, 0, 0, 1, 0, 7, 0, 0, 0, "t3.haz");
        step(0, 1, 7, 32'd9, 1, 0, 7, 0, 0, 0, "t3.wbrd");
        step(0, 0, 0, 0, 1, 0, 7, 0, 0, 0, "t3.rd2");
        idle("t3.chk");

        // 4: counter saturation and same-cycle issue/write-back
        do_rst("t4.rst");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, "t4.i1");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, "t4.i2");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, "t4.i3");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, "t4.i4");
        step(0, 1, 4, 32'h44, 0, 0, 0, 1, 1, 4, "t4.iwb");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, "t4.i5");
        idle("t4.chk");

        // 5: sticky error on unexpected write-back, cleared by reset
        do_rst("t5.rst");
        step(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, "t5.wb");
        idle("t5.s1");
        step(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, "t5.rd");
        idle("t5.chk");
        do_rst("t5.rst2");
        step(0, 0, 0, 0, 1, 4, 9, 0, 0, 0, "t5.rdz");
        idle("t5.chk2");

        // 6: reset with a write-back in flight
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, "t6.i1");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, "t6.i2");
        step(1, 1, 2, 32'h22, 1, 2, 2, 0, 0, 0, "t6.rst");
        step(0, 0, 0, 0, 1, 2, 2, 0, 0, 0, "t6.rd");
        idle("t6.chk");

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 800; n++) begin
            cand.delete();
            for (int r = 1; r < 8; r++) if (m_pend[r] > 0) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(0, 9) < 8)
                rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                rd = 5'($urandom_range(0, 7));
            a1  = 5'($urandom_range(0, 7));
            a2  = 5'($urandom_range(0, 7));
            ird = 5'($urandom_range(0, 7));
            d   = $urandom;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, rd, d,
                 $urandom_range(0, 1) == 1, a1, a2,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, ird, "rnd");
        end

        idle("end0");
        idle("end1");
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
